// File: rtl/imm_gen_pkg.sv
// Shared types and encodings for the pipelined immediate generator.
// The optional illegal-word flag is enabled by defining IMM_GEN_ILLEGAL_EN.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> extended immediate and format tag.
// With IMM_GEN_ILLEGAL_EN defined, an illegal output flags undecodable words.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_code,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;
  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     i32, s32, b32, u32, j32;
  logic            is_shift, f7_ok7, f7_ok6, bad;
  logic [XLEN-1:0] raw_imm;
  imm_fmt_e        raw_fmt;

  // Widen an already sign-extended 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  assign opcode   = inst_code[6:0];
  assign funct3   = inst_code[14:12];
  assign i32      = {{20{inst_code[31]}}, inst_code[31:20]};
  assign s32      = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
  assign b32      = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                     inst_code[30:25], inst_code[11:8], 1'b0};
  assign u32      = {inst_code[31:12], 12'b0};
  assign j32      = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                     inst_code[20], inst_code[30:21], 1'b0};
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);
  assign f7_ok7   = (inst_code[31:25] == 7'b0000000) ||
                    ((funct3 == F3_SRX) && (inst_code[31:25] == 7'b0100000));
  assign f7_ok6   = (inst_code[31:26] == 6'b000000) ||
                    ((funct3 == F3_SRX) && (inst_code[31:26] == 6'b010000));

  always_comb begin
    raw_imm = '0;
    raw_fmt = FMT_NONE;
    bad     = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        raw_imm = sx(i32);
        raw_fmt = FMT_I;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          raw_imm = XLEN'(inst_code[20 +: SHAMT_W]);
          raw_fmt = FMT_SHAMT;
          bad     = RV64 ? !f7_ok6 : !f7_ok7;
        end else begin
          raw_imm = sx(i32);
          raw_fmt = FMT_I;
        end
      end
      OPC_OP_IMM_32: begin
        if (RV64) begin
          if (is_shift) begin
            raw_imm = XLEN'(inst_code[24:20]);
            raw_fmt = FMT_SHAMT;
            bad     = !f7_ok7;
          end else begin
            raw_imm = sx(i32);
            raw_fmt = FMT_I;
          end
        end else begin
          bad = 1'b1;
        end
      end
      OPC_STORE: begin
        raw_imm = sx(s32);
        raw_fmt = FMT_S;
      end
      OPC_BRANCH: begin
        raw_imm = sx(b32);
        raw_fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw_imm = sx(u32);
        raw_fmt = FMT_U;
      end
      OPC_JAL: begin
        raw_imm = sx(j32);
        raw_fmt = FMT_J;
      end
      default: bad = 1'b1;
    endcase
  end

  // Undecodable encodings always present as a zero immediate with no format.
  assign imm = bad ? '0 : raw_imm;
  assign fmt = bad ? FMT_NONE : raw_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal = bad;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decoder followed by a 2-entry skid buffer.
// Define IMM_GEN_ILLEGAL_EN to add the per-entry illegal output.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output imm_fmt_e        imm_fmt
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  logic [XLEN-1:0] ent_imm_q [2];
  logic [XLEN-1:0] ent_imm_d [2];
  imm_fmt_e        ent_fmt_q [2];
  imm_fmt_e        ent_fmt_d [2];
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_code (inst_code),
    .imm       (dec_imm),
    .fmt       (dec_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal   (dec_illegal)
`endif
  );

`ifndef IMM_GEN_ILLEGAL_EN
  assign dec_illegal = 1'b0;
`endif

  logic ent_ill_q [2];
  logic ent_ill_d [2];

  assign out_valid = (count_q != 2'd0);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    // Ready comes from the next count, so it never depends on out_ready combinationally.
    in_ready_d = (count_d != 2'd2);
    for (int i = 0; i < 2; i++) begin
      ent_imm_d[i] = ent_imm_q[i];
      ent_fmt_d[i] = ent_fmt_q[i];
      ent_ill_d[i] = ent_ill_q[i];
      if (push && (wr_ptr_q == 1'(i))) begin
        ent_imm_d[i] = dec_imm;
        ent_fmt_d[i] = dec_fmt;
        ent_ill_d[i] = dec_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        ent_imm_q[i] <= '0;
        ent_fmt_q[i] <= FMT_NONE;
        ent_ill_q[i] <= 1'b0;
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < 2; i++) begin
        ent_imm_q[i] <= ent_imm_d[i];
        ent_fmt_q[i] <= ent_fmt_d[i];
        ent_ill_q[i] <= ent_ill_d[i];
      end
    end
  end

  assign imm_out = out_valid ? ent_imm_q[rd_ptr_q] : '0;
  assign imm_fmt = out_valid ? ent_fmt_q[rd_ptr_q] : FMT_NONE;
`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal = out_valid && ent_ill_q[rd_ptr_q];
`else
  logic unused_ill;
  assign unused_ill = ^{ent_ill_q[0], ent_ill_q[1]};
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32); covers decode, buffering, and reset.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst_code;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  imm_fmt_e        imm_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
  logic            illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst_code (inst_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .imm_fmt   (imm_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word through an empty (or draining, count 1) buffer with out_ready high.
  task automatic xfer(input string tag, input logic [31:0] inst,
                      input logic [XLEN-1:0] e_imm, input imm_fmt_e e_fmt, input logic e_ill);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    inst_code = inst;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(imm_out), 64'(e_imm));
    chk({tag, "_fmt"}, 64'(imm_fmt), 64'(e_fmt));
`ifdef IMM_GEN_ILLEGAL_EN
    chk({tag, "_illegal"}, 64'(illegal), 64'(e_ill));
`endif
    $display("xfer %s inst=%08h imm=%08h fmt=%0d", tag, inst, imm_out, imm_fmt);
  endtask

  logic [31:0] st_inst [4];
  logic [31:0] st_imm  [4];
  imm_fmt_e    st_fmt  [4];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    inst_code = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm_out), 64'd0);
    chk("rst_fmt", 64'(imm_fmt), 64'(FMT_NONE));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Single-word decode across formats
    xfer("addi", 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);
    xfer("beq", 32'hFE000EE3, 32'hFFFFFFFC, FMT_B, 1'b0);
    xfer("lui", 32'h123452B7, 32'h12345000, FMT_U, 1'b0);
    xfer("srai", 32'h4030D093, 32'h00000003, FMT_SHAMT, 1'b0);
    xfer("jal", 32'hFF9FF06F, 32'hFFFFFFF8, FMT_J, 1'b0);
    xfer("sw", 32'hFE20AC23, 32'hFFFFFFF8, FMT_S, 1'b0);
    xfer("lw", 32'h00412083, 32'h00000004, FMT_I, 1'b0);
    xfer("undef", 32'h0000007F, 32'h00000000, FMT_NONE, 1'b1);
    xfer("slli_bad_f7", 32'h40109093, 32'h00000000, FMT_NONE, 1'b1);
    xfer("addiw_rv32", 32'h0010809B, 32'h00000000, FMT_NONE, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: three words offered with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_code = 32'hFFF00093;
    @(posedge clk);
    @(negedge clk);
    inst_code = 32'h123452B7;
    @(posedge clk);
    @(negedge clk);
    inst_code = 32'hFF9FF06F;
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_imm", 64'(imm_out), 64'h00000000FFFFFFFF);
    $display("bp hold head=%08h", imm_out);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_imm", 64'(imm_out), 64'h0000000012345000);
    chk("bp_second_fmt", 64'(imm_fmt), 64'(FMT_U));
    chk("bp_reopen_in_ready", 64'(in_ready), 64'd1);
    $display("bp out=%08h", imm_out);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_third_imm", 64'(imm_out), 64'h00000000FFFFFFF8);
    chk("bp_third_fmt", 64'(imm_fmt), 64'(FMT_J));
    $display("bp out=%08h", imm_out);
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty_valid", 64'(out_valid), 64'd0);

    // Streaming: one word per cycle in and out
    st_inst[0] = 32'hFFF00093; st_imm[0] = 32'hFFFFFFFF; st_fmt[0] = FMT_I;
    st_inst[1] = 32'hFE000EE3; st_imm[1] = 32'hFFFFFFFC; st_fmt[1] = FMT_B;
    st_inst[2] = 32'h4030D093; st_imm[2] = 32'h00000003; st_fmt[2] = FMT_SHAMT;
    st_inst[3] = 32'h123452B7; st_imm[3] = 32'h12345000; st_fmt[3] = FMT_U;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid  = 1'b1;
      inst_code = st_inst[k];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stream%0d_imm", k), 64'(imm_out), 64'(st_imm[k]));
      chk($sformatf("stream%0d_fmt", k), 64'(imm_fmt), 64'(st_fmt[k]));
      chk($sformatf("stream%0d_in_ready", k), 64'(in_ready), 64'd1);
      $display("stream %0d out=%08h fmt=%0d", k, imm_out, imm_fmt);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset with a full buffer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_code = 32'hFFF00093;
    @(posedge clk);
    @(negedge clk);
    inst_code = 32'hFE000EE3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_imm", 64'(imm_out), 64'd0);
    chk("midrst_fmt", 64'(imm_fmt), 64'(FMT_NONE));
    $display("mid-stream reset valid=%0b imm=%08h", out_valid, imm_out);
    @(posedge clk);
    @(negedge clk);
    xfer("post_rst_lui", 32'h123452B7, 32'h12345000, FMT_U, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_drain", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
